capture_ctrl: RTL

Sequences one acquisition of the logic-analyzer sample RAM around the channel trigger logic. Each capture runs idle → pre-trigger fill → armed → post-trigger count → done → readout.
- Drives the circular RAM write address and write enable.
- Asserts armed to the trigger logic once enough pre-trigger history exists.
- Pulses set_capture_done after the programmed number of post-trigger samples.
- Streams the buffer out oldest-first over a valid/ack handshake.

---
 rtl/cap_pkg.sv | 6 +
 rtl/circ_addr_ctr.sv | 21 ++
 rtl/capture_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/cap_pkg.sv
// Shared types for the logic-analyzer capture sequencer.
package cap_pkg;
  localparam int ADDR_W_DEF = 9;

  typedef enum logic [2:0] {IDLE, CAPTURE, POST, DONE, DUMP} state_e;
endpackage

// File: rtl/circ_addr_ctr.sv
// Wrapping RAM address counter; load has priority over increment.
module circ_addr_ctr #(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_i,
  input  logic [ADDR_W-1:0] ld_val_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] cnt_o
);
  logic [ADDR_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     cnt_q <= '0;
    else if (ld_i)  cnt_q <= ld_val_i;
    else if (inc_i) cnt_q <= cnt_q + 1'b1;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/capture_ctrl.sv
// Capture sequencer: pre-trigger fill, armed wait, post-trigger count,
// then oldest-first readout of the circular sample RAM.
module capture_ctrl
  import cap_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              wrt_smpl,
  input  logic              triggered,
  input  logic [ADDR_W-1:0] trig_pos,
  input  logic              dump_go,
  input  logic              rd_ack,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W-1:0] raddr,
  output logic              rd_vld,
  output logic              armed,
  output logic              set_capture_done,
  output logic              capture_done
);
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  state_e            state_q;
  logic [ADDR_W:0]   smpl_cnt_q, post_cnt_q, rd_cnt_q;
  logic [ADDR_W-1:0] start_addr_q;
  logic              armed_q, rd_vld_q, scd_q, cd_q;

  logic [ADDR_W:0]   tp_ext, thr, smpl_nxt, post_nxt;
  logic              cap_wr, post_last, r_ld, r_inc;

  assign tp_ext   = {1'b0, trig_pos};
  // Evaluated at ADDR_W+1 bits so trig_pos==0 yields DEPTH, not zero.
  assign thr      = DEPTH - tp_ext;
  assign smpl_nxt = (smpl_cnt_q == DEPTH) ? DEPTH : smpl_cnt_q + 1'b1;
  assign post_nxt = post_cnt_q + 1'b1;

  // Abort (run=0) suppresses the write; POST stops writing once the count is met.
  assign cap_wr    = wrt_smpl && run &&
                     (state_q == CAPTURE || (state_q == POST && post_cnt_q != tp_ext));
  assign post_last = cap_wr && state_q == POST && post_nxt == tp_ext;
  assign r_ld      = state_q == DONE && run && dump_go;
  assign r_inc     = state_q == DUMP && run && rd_ack && rd_vld_q;

  circ_addr_ctr #(.ADDR_W(ADDR_W)) u_wctr (
    .clk(clk), .rst_n(rst_n), .ld_i(1'b0), .ld_val_i('0), .inc_i(cap_wr), .cnt_o(waddr)
  );

  circ_addr_ctr #(.ADDR_W(ADDR_W)) u_rctr (
    .clk(clk), .rst_n(rst_n), .ld_i(r_ld), .ld_val_i(start_addr_q), .inc_i(r_inc), .cnt_o(raddr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      smpl_cnt_q   <= '0;
      post_cnt_q   <= '0;
      rd_cnt_q     <= '0;
      start_addr_q <= '0;
      armed_q      <= 1'b0;
      rd_vld_q     <= 1'b0;
      scd_q        <= 1'b0;
      cd_q         <= 1'b0;
    end else begin
      scd_q <= 1'b0;
      case (state_q)
        IDLE: if (run) begin
          state_q    <= CAPTURE;
          smpl_cnt_q <= '0;
        end
        CAPTURE: begin
          if (!run) begin
            state_q <= IDLE;
            armed_q <= 1'b0;
          end else begin
            if (cap_wr) begin
              smpl_cnt_q <= smpl_nxt;
              if (smpl_nxt >= thr) armed_q <= 1'b1;
            end
            if (armed_q && triggered) begin
              state_q    <= POST;
              post_cnt_q <= '0;
            end
          end
        end
        POST: begin
          if (!run) begin
            state_q <= IDLE;
            armed_q <= 1'b0;
          end else begin
            if (cap_wr) post_cnt_q <= post_nxt;
            if (post_last || post_cnt_q == tp_ext) begin
              state_q      <= DONE;
              scd_q        <= 1'b1;
              cd_q         <= 1'b1;
              armed_q      <= 1'b0;
              // waddr after this cycle's write points at the oldest sample
              start_addr_q <= waddr + ADDR_W'(cap_wr);
            end
          end
        end
        DONE: begin
          if (!run) begin
            state_q <= IDLE;
            cd_q    <= 1'b0;
          end else if (dump_go) begin
            state_q  <= DUMP;
            rd_vld_q <= 1'b1;
            rd_cnt_q <= '0;
          end
        end
        DUMP: begin
          if (!run) begin
            state_q  <= IDLE;
            rd_vld_q <= 1'b0;
            cd_q     <= 1'b0;
          end else if (r_inc) begin
            rd_cnt_q <= rd_cnt_q + 1'b1;
            if (rd_cnt_q + 1'b1 == DEPTH) begin
              state_q  <= IDLE;
              rd_vld_q <= 1'b0;
              cd_q     <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign we               = cap_wr;
  assign armed            = armed_q;
  assign rd_vld           = rd_vld_q;
  assign set_capture_done = scd_q;
  assign capture_done     = cd_q;
endmodule
